// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU (add/sub/and/xor/slt)
// between two requesters. Each operation is granted from IDLE, executes for
// one cycle (EXEC) on registered ALU inputs, and is returned on the owner's
// response channel (RESP) until that requester takes it.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req{0,1}_valid/ready       request handshake (ready is combinational)
//   req{0,1}_op/a/b            opcode and operands
//   resp{0,1}_valid/ready      response handshake
//   resp{0,1}_data/err         result, illegal-opcode flag
//   alu_a, alu_b, alu_control  registered drive of the shared ALU
//   alu_result                 combinational ALU result
//   busy                       high whenever the FSM is not IDLE
module alu_share_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic             resp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Highest legal opcode (slt); anything above is illegal.
  localparam logic [2:0] OP_LAST = 3'b100;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner;
  logic       last_grant;
  logic       grant0_c;
  logic       grant1_c;
  logic       resp_done_c;
  logic       op_illegal_c;

  // Grant decision: only meaningful in IDLE. Round-robin favours the
  // requester that did not win last time; fixed priority favours 0.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        if ((FIXED_PRIO != 0) || last_grant) grant0_c = 1'b1;
        else                                 grant1_c = 1'b1;
      end else if (req0_valid) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign req0_ready   = grant0_c;
  assign req1_ready   = grant1_c;
  assign busy         = (state != S_IDLE);
  assign op_illegal_c = (alu_control > OP_LAST);
  assign resp_done_c  = owner ? resp1_ready : resp0_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant0_c || grant1_c) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (resp_done_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the winner's operation on grant, capture the ALU result
  // at the end of EXEC, and hold the response until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 3'b000;
      resp0_valid <= 1'b0;
      resp0_data  <= '0;
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_data  <= '0;
      resp1_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0_c || grant1_c) begin
            alu_a       <= grant1_c ? req1_a  : req0_a;
            alu_b       <= grant1_c ? req1_b  : req0_b;
            alu_control <= grant1_c ? req1_op : req0_op;
            owner       <= grant1_c;
            last_grant  <= grant1_c;
          end
        end
        S_EXEC: begin
          if (!owner) begin
            resp0_valid <= 1'b1;
            resp0_data  <= op_illegal_c ? '0 : alu_result;
            resp0_err   <= op_illegal_c;
          end else begin
            resp1_valid <= 1'b1;
            resp1_data  <= op_illegal_c ? '0 : alu_result;
            resp1_err   <= op_illegal_c;
          end
        end
        S_RESP: begin
          if (!owner && resp0_ready) resp0_valid <= 1'b0;
          if (owner && resp1_ready)  resp1_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
